// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Bundles the control-unit handshake and the RAM port of mem_access_ctrl.
//   master : the controller itself (drives ready/done/rdata and the RAM port)
//   slave  : the environment (control unit + RAM model)
// Signals
//   req, we, size, sign_ext, addr, wdata   request from the control unit
//   ready, done, rdata, misalign_err       handshake / result to the control unit
//   Mem_Addr, Mem_Data, Mem_W_EN, Mem_sel  RAM address, write data, write enable, write mode
//   Mem_Out_Data                           RAM combinational read word
interface mem_access_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req;
  logic                     we;
  logic [1:0]               size;
  logic                     sign_ext;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     ready;
  logic                     done;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     misalign_err;
  logic [ADDRESS_WIDTH-1:0] Mem_Addr;
  logic [DATA_WIDTH-1:0]    Mem_Data;
  logic                     Mem_W_EN;
  logic [1:0]               Mem_sel;
  logic [DATA_WIDTH-1:0]    Mem_Out_Data;

  modport master (
    input  req, we, size, sign_ext, addr, wdata, Mem_Out_Data,
    output ready, done, rdata, misalign_err, Mem_Addr, Mem_Data, Mem_W_EN, Mem_sel
  );

  modport slave (
    output req, we, size, sign_ext, addr, wdata, Mem_Out_Data,
    input  ready, done, rdata, misalign_err, Mem_Addr, Mem_Data, Mem_W_EN, Mem_sel
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory-side master for the multi-cycle MIPS datapath. Accepts one
//   load/store at a time (req/ready/done), drives the byte-addressable RAM
//   port and returns a sign/zero-extended, registered load result.
// Ports
//   CLK  : clock, all state updates on the rising edge
//   RST  : synchronous active-low reset
//   bus  : mem_access_ctrl_if.master (handshake + RAM port)
// Parameters
//   ADDRESS_WIDTH, DATA_WIDTH (must be 32), WAIT_CYCLES (0..15)
// Build option
//   MISALIGN_TRAP_EN defined   : misaligned requests end in ERR (done + misalign_err)
//   MISALIGN_TRAP_EN undefined : low address bits are forced aligned, no ERR state
module mem_access_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int WAIT_CYCLES   = 0
) (
  input  logic               CLK,
  input  logic               RST,
  mem_access_ctrl_if.master  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCESS = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
`ifdef MISALIGN_TRAP_EN
  localparam logic [2:0] S_ERR    = 3'd4;
`endif

  // WAIT counts down from WAIT_CYCLES-1 to 0, so it lasts WAIT_CYCLES cycles
  localparam int         WAIT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] WAIT_LOAD = WAIT_INIT[3:0];

  logic [2:0]               state_q, state_d;
  logic [3:0]               wcnt_q, wcnt_d;
  logic                     we_q, sext_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               sel_q;

  logic                     accept;
  logic [1:0]               sel_in;
  logic [ADDRESS_WIDTH-1:0] addr_in;
  logic                     capture;
  logic [DATA_WIDTH-1:0]    ext;

  assign accept = (state_q == S_IDLE) && bus.req;

  // size 11 is just another byte encoding; the RAM only sees 00/01/10
  assign sel_in = (bus.size == 2'b11) ? 2'b10 : bus.size;

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((bus.size == 2'b00) && (bus.addr[1:0] != 2'b00)) ||
                      ((bus.size == 2'b01) && bus.addr[0]);
  assign addr_in    = bus.addr;
`else
  // Without the trap the request is silently aligned to its natural boundary
  always_comb begin
    addr_in = bus.addr;
    case (bus.size)
      2'b00:   addr_in[1:0] = 2'b00;
      2'b01:   addr_in[0]   = 1'b0;
      default: addr_in      = bus.addr;
    endcase
  end
`endif

  // Next-state / wait counter
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
`ifdef MISALIGN_TRAP_EN
          state_d = misaligned ? S_ERR : S_ACCESS;
`else
          state_d = S_ACCESS;
`endif
        end
      end
      S_ACCESS: begin
        if (WAIT_CYCLES > 0) begin
          state_d = S_WAIT;
          wcnt_d  = WAIT_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) state_d = S_DONE;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      default: state_d = S_IDLE;  // DONE, ERR and any illegal encoding
    endcase
  end

  // The RAM presents the word starting at the latched byte address, so the
  // addressed byte/half always sits in the low bits of Mem_Out_Data.
  always_comb begin
    case (sel_q)
      2'b10:   ext = {{(DATA_WIDTH-8){sext_q & bus.Mem_Out_Data[7]}},
                      bus.Mem_Out_Data[7:0]};
      2'b01:   ext = {{(DATA_WIDTH-16){sext_q & bus.Mem_Out_Data[15]}},
                      bus.Mem_Out_Data[15:0]};
      default: ext = bus.Mem_Out_Data;
    endcase
  end

  // Only ACCESS/WAIT can move to DONE, so this is the last data-valid edge
  assign capture = (state_d == S_DONE) && !we_q;

  always_comb begin
    rdata_d = rdata_q;
    if (capture) rdata_d = ext;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      wcnt_q  <= 4'd0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= bus.we;
        sext_q  <= bus.sign_ext;
        addr_q  <= addr_in;
        wdata_q <= bus.wdata;
        sel_q   <= sel_in;
      end
    end
  end

  assign bus.ready    = (state_q == S_IDLE);
`ifdef MISALIGN_TRAP_EN
  assign bus.done         = (state_q == S_DONE) || (state_q == S_ERR);
  assign bus.misalign_err = (state_q == S_ERR);
`else
  assign bus.done         = (state_q == S_DONE);
  assign bus.misalign_err = 1'b0;
`endif
  assign bus.rdata    = rdata_q;
  assign bus.Mem_Addr = addr_q;
  assign bus.Mem_Data = wdata_q;
  assign bus.Mem_sel  = sel_q;
  assign bus.Mem_W_EN = (state_q == S_ACCESS) && we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with WAIT_CYCLES=0 (u0)
// and one with WAIT_CYCLES=3 (u3) share a byte-addressable RAM model.
module tb_mem_access_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  mem_access_ctrl_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  mem_access_ctrl_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) b3 ();

  mem_access_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(0))
    u0 (.CLK(CLK), .RST(RST), .bus(b0));
  mem_access_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .WAIT_CYCLES(3))
    u3 (.CLK(CLK), .RST(RST), .bus(b3));

  logic        req0, req3, we, sext, ram_clr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;

  assign b0.req = req0;  assign b3.req = req3;
  assign b0.we = we;     assign b3.we = we;
  assign b0.size = size; assign b3.size = size;
  assign b0.sign_ext = sext; assign b3.sign_ext = sext;
  assign b0.addr = addr;  assign b3.addr = addr;
  assign b0.wdata = wdata; assign b3.wdata = wdata;

  // RAM model: 256 bytes, little-endian window read at the byte address
  logic [7:0] ram [0:255];
  logic [7:0] a0, a3;
  assign a0 = b0.Mem_Addr[7:0];
  assign a3 = b3.Mem_Addr[7:0];
  assign b0.Mem_Out_Data = {ram[a0 + 8'd3], ram[a0 + 8'd2], ram[a0 + 8'd1], ram[a0]};
  assign b3.Mem_Out_Data = {ram[a3 + 8'd3], ram[a3 + 8'd2], ram[a3 + 8'd1], ram[a3]};

  logic        wen;
  logic [7:0]  wa;
  logic [31:0] wd;
  logic [1:0]  ws;
  assign wen = b0.Mem_W_EN | b3.Mem_W_EN;
  assign wa  = b0.Mem_W_EN ? a0 : a3;
  assign wd  = b0.Mem_W_EN ? b0.Mem_Data : b3.Mem_Data;
  assign ws  = b0.Mem_W_EN ? b0.Mem_sel : b3.Mem_sel;

  always @(posedge CLK) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (wen) begin
      ram[wa] <= wd[7:0];
      if (ws != 2'b10) ram[wa + 8'd1] <= wd[15:8];
      if (ws == 2'b00) begin
        ram[wa + 8'd2] <= wd[23:16];
        ram[wa + 8'd3] <= wd[31:24];
      end
    end
  end

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request on u0 or u3 and watch up to 14 cycles after the accept
  // edge. Cycle k is sampled on the k-th falling edge after the accept edge.
  // rst_cyc != 0 pulls RST low during that cycle and releases it two cycles later.
  task automatic op(input bit u3, input logic w, input logic [1:0] sz, input logic sx,
                    input logic [31:0] a, input logic [31:0] wdt, input int rst_cyc,
                    output int dcyc, output int wcnt, output int dcnt,
                    output logic [1:0] wsel, output logic [31:0] wadr,
                    output logic mis, output int bad);
    logic d, m, e;
    dcyc = 0; wcnt = 0; dcnt = 0; wsel = 2'b11; wadr = '0; mis = 1'b0; bad = 0;
    @(negedge CLK);
    we = w; size = sz; sext = sx; addr = a; wdata = wdt;
    if (u3) req3 = 1'b1; else req0 = 1'b1;
    @(posedge CLK);
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      // inputs scrambled after the accept must not matter
      req0 = 1'b0; req3 = 1'b0; we = ~w; size = ~sz; sext = ~sx;
      addr = $urandom(); wdata = $urandom();
      d = u3 ? b3.done : b0.done;
      m = u3 ? b3.misalign_err : b0.misalign_err;
      e = u3 ? b3.Mem_W_EN : b0.Mem_W_EN;
      if (e) begin
        wcnt++;
        wsel = u3 ? b3.Mem_sel : b0.Mem_sel;
        wadr = u3 ? b3.Mem_Addr : b0.Mem_Addr;
      end
      if (m && !d) bad++;
      if (d) begin
        dcnt++;
        if (dcyc == 0) begin dcyc = k; mis = m; end
      end
      if (rst_cyc != 0 && k == rst_cyc)     RST = 1'b0;
      if (rst_cyc != 0 && k == rst_cyc + 2) RST = 1'b1;
      if (d && rst_cyc == 0) break;
    end
  endtask

  int          dcyc, wcnt, dcnt, bad;
  logic [1:0]  wsel;
  logic [31:0] wadr;
  logic        mis;

  initial begin
    ram_clr = 1'b1; req0 = 1'b0; req3 = 1'b0; we = 1'b0; sext = 1'b0;
    size = 2'b00; addr = '0; wdata = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1; ram_clr = 1'b0;
    chk("rst_ready",  {31'd0, b0.ready},        32'd1);
    chk("rst_done",   {31'd0, b0.done},         32'd0);
    chk("rst_wen",    {31'd0, b0.Mem_W_EN},     32'd0);
    chk("rst_rdata",  b0.rdata,                 32'd0);
    chk("rst_mis",    {31'd0, b0.misalign_err}, 32'd0);
    chk("rst_addr",   b0.Mem_Addr,              32'd0);
    chk("rst_mdata",  b0.Mem_Data,              32'd0);
    chk("rst_sel",    {30'd0, b0.Mem_sel},      32'd0);
    chk("rst_ready3", {31'd0, b3.ready},        32'd1);

    // store word
    op(0, 1, 2'b00, 0, 32'h40, 32'h8899AABB, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("stw_dcyc", 32'(dcyc), 32'd2);
    chk("stw_wcnt", 32'(wcnt), 32'd1);
    chk("stw_sel",  {30'd0, wsel}, 32'd0);
    chk("stw_addr", wadr, 32'h40);
    chk("stw_mis",  {31'd0, mis}, 32'd0);
    chk("stw_rdata_kept", b0.rdata, 32'd0);

    // load word
    op(0, 0, 2'b00, 0, 32'h40, 32'h0, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("ldw_dcyc",  32'(dcyc), 32'd2);
    chk("ldw_wcnt",  32'(wcnt), 32'd0);
    chk("ldw_rdata", b0.rdata, 32'h8899AABB);
    @(negedge CLK);
    chk("ldw_ready_after", {31'd0, b0.ready}, 32'd1);

    // sub-word loads
    op(0, 0, 2'b10, 1, 32'h41, 32'h0, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("ldb41_sx", b0.rdata, 32'hFFFFFFAA);
    op(0, 0, 2'b10, 0, 32'h41, 32'h0, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("ldb41_zx", b0.rdata, 32'h000000AA);
    op(0, 0, 2'b01, 1, 32'h42, 32'h0, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("ldh42_sx", b0.rdata, 32'hFFFF8899);
    op(0, 0, 2'b10, 0, 32'h43, 32'h0, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("ldb43_zx", b0.rdata, 32'h00000088);
    op(0, 0, 2'b11, 1, 32'h43, 32'h0, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("ldb43_sz11", b0.rdata, 32'hFFFFFF88);
    chk("ldb43_sel",  {30'd0, b0.Mem_sel}, 32'd2);

    // store byte, read back word
    op(0, 1, 2'b10, 0, 32'h42, 32'hFFFFFF5C, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("stb_sel",  {30'd0, wsel}, 32'd2);
    chk("stb_wcnt", 32'(wcnt), 32'd1);
    chk("stb_addr", wadr, 32'h42);
    op(0, 0, 2'b00, 0, 32'h40, 32'h0, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("ldw_after_stb", b0.rdata, 32'h885CAABB);

    // misaligned accesses
    op(0, 0, 2'b00, 0, 32'h41, 32'h0, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("misw_wcnt", 32'(wcnt), 32'd0);
    chk("misw_bad",  32'(bad), 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk("misw_dcyc",  32'(dcyc), 32'd1);
    chk("misw_err",   {31'd0, mis}, 32'd1);
    chk("misw_rdata", b0.rdata, 32'h885CAABB);
`else
    chk("misw_dcyc",  32'(dcyc), 32'd2);
    chk("misw_err",   {31'd0, mis}, 32'd0);
    chk("misw_addr",  b0.Mem_Addr, 32'h40);
    chk("misw_rdata", b0.rdata, 32'h885CAABB);
`endif
    op(0, 0, 2'b01, 0, 32'h43, 32'h0, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
`ifdef MISALIGN_TRAP_EN
    chk("mish_err",   {31'd0, mis}, 32'd1);
    chk("mish_rdata", b0.rdata, 32'h885CAABB);
`else
    chk("mish_err",   {31'd0, mis}, 32'd0);
    chk("mish_addr",  b0.Mem_Addr, 32'h42);
    chk("mish_rdata", b0.rdata, 32'h0000885C);
`endif

    // misaligned store: no write pulse when trapped, aligned write otherwise
    op(0, 1, 2'b00, 0, 32'h42, 32'h11223344, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
`ifdef MISALIGN_TRAP_EN
    chk("missw_wcnt", 32'(wcnt), 32'd0);
    chk("missw_err",  {31'd0, mis}, 32'd1);
`else
    chk("missw_wcnt", 32'(wcnt), 32'd1);
    chk("missw_addr", wadr, 32'h40);
    // restore the word the later checks rely on
    op(0, 1, 2'b00, 0, 32'h40, 32'h885CAABB, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
`endif

    // WAIT_CYCLES=3: reset during cycle 2 aborts the load silently
    op(1, 0, 2'b00, 0, 32'h40, 32'h0, 2, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("w3_abort_done", 32'(dcnt), 32'd0);
    chk("w3_abort_ready", {31'd0, b3.ready}, 32'd1);
    chk("w3_abort_rdata", b3.rdata, 32'd0);

    op(1, 0, 2'b00, 0, 32'h40, 32'h0, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("w3_ld_dcyc",  32'(dcyc), 32'd5);
    chk("w3_ld_rdata", b3.rdata, 32'h885CAABB);

    op(1, 1, 2'b01, 0, 32'h40, 32'hABCD1234, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("w3_sth_dcyc", 32'(dcyc), 32'd5);
    chk("w3_sth_wcnt", 32'(wcnt), 32'd1);
    chk("w3_sth_sel",  {30'd0, wsel}, 32'd1);
    chk("w3_sth_rdata_kept", b3.rdata, 32'h885CAABB);

    op(0, 0, 2'b00, 0, 32'h40, 32'h0, 0, dcyc, wcnt, dcnt, wsel, wadr, mis, bad);
    chk("ldw_after_sth", b0.rdata, 32'h885C1234);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  // global guard so a stuck handshake cannot hang the run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-side master for the multi-cycle MIPS datapath; the initiator end of the byte-addressable data/instruction RAM port.
- Accepts one load/store request at a time from the control unit through a req/ready/done handshake.
- Drives the RAM address, write data, write enable and write-mode select.
- For loads, extracts the addressed byte/halfword/word lane from the little-endian 32-bit read word and sign- or zero-extends it into a registered result.

Parameters:
ADDRESS_WIDTH, 32, width of addr and Mem_Addr
DATA_WIDTH, 32, width of wdata, rdata, Mem_Data, Mem_Out_Data; must be 32
WAIT_CYCLES, 0, extra wait cycles between address presentation and read-data capture (0..15)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-low reset
req  input  1  request strobe, sampled only when ready=1
we  input  1  1=store, 0=load
size  input  2  00=word, 01=half, 10=byte, 11=byte (same encoding as RAM sel)
sign_ext  input  1  loads only: 1=sign-extend, 0=zero-extend
addr  input  ADDRESS_WIDTH  byte address
wdata  input  DATA_WIDTH  store data, low-aligned (half in [15:0], byte in [7:0])
ready  output  1  1 only in IDLE
done  output  1  one-cycle completion pulse
rdata  output  DATA_WIDTH  registered extended load result
misalign_err  output  1  valid with done; 1=request rejected
Mem_Addr  output  ADDRESS_WIDTH  RAM byte address
Mem_Data  output  DATA_WIDTH  RAM write data
Mem_W_EN  output  1  RAM write enable
Mem_sel  output  2  RAM write mode
Mem_Out_Data  input  DATA_WIDTH  RAM combinational read word {b[A+3],b[A+2],b[A+1],b[A]}

Behaviour:
- States: IDLE, ACCESS, WAIT, DONE, ERR.
- Reset (RST=0 at an edge):
  - State goes to IDLE, including from mid-operation; the aborted request produces no done.
  - Reset values: ready=1, done=0, rdata=0, misalign_err=0, Mem_W_EN=0, Mem_Addr=0, Mem_Data=0, Mem_sel=00.
- IDLE:
  - Edge with req=1 accepts the request (E0).
  - addr, we, size, sign_ext and wdata are latched. Mem_Addr, Mem_Data and Mem_sel are loaded from addr, wdata and size (11 maps to 10).
  - Misaligned request goes to ERR; otherwise goes to ACCESS.
  - Misaligned: size=00 with addr[1:0]!=0, or size=01 with addr[0]=1.
  - Input changes after E0 are ignored until ready returns.
- ACCESS:
  - Exactly one cycle.
  - Mem_W_EN=1 for this cycle only, if we=1.
  - Next state is WAIT if WAIT_CYCLES>0, else DONE.
- WAIT:
  - Counter runs WAIT_CYCLES cycles, then DONE.
  - Mem_W_EN=0; Mem_Addr held.
- Capture, on the edge leaving ACCESS/WAIT into DONE, loads only:
  - lane = addr[1:0].
  - Byte: Mem_Out_Data[7:0] is the byte at the latched address; upper bits are bit 7 when sign_ext=1, else 0.
  - Half: Mem_Out_Data[15:0] at the address; extended from bit 15 (sign_ext=1) or with zeros.
  - Word: Mem_Out_Data unchanged.
  - Stores leave rdata unchanged.
- DONE:
  - done=1 and misalign_err=0 for one cycle, then IDLE.
  - Store completion therefore guarantees the RAM write edge has occurred.
- ERR:
  - done=1 and misalign_err=1 for one cycle, then IDLE.
  - No Mem_W_EN pulse; rdata unchanged.
- Latency:
  - done is high during cycle 2+WAIT_CYCLES after E0 (counting E0's following cycle as 1).
  - ERR: done is high in cycle 1.
  - ready=0 from E0 until the edge leaving DONE/ERR; the earliest next accept is the edge after done.
- misalign_err is 0 whenever done=0.
- Mem_W_EN is never high outside ACCESS.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: misaligned requests are trapped via ERR as described above.
- Undefined:
  - No ERR state; misalign_err tied 0.
  - Address low bits are forced aligned before latching: addr[1:0]=00 for word, addr[0]=0 for half.
  - The request proceeds normally with that aligned address, and the lane is taken from the aligned address.

Test Plan:
- Reset then idle: hold RST=0 two cycles, release -> ready=1, done=0, Mem_W_EN=0, rdata=0.
- Store word: addr=0x40, wdata=0x8899AABB, size=00, WAIT_CYCLES=0 -> Mem_W_EN high exactly one cycle with Mem_sel=00 and Mem_Addr=0x40. done in cycle 2. Then load word 0x40 -> rdata=0x8899AABB.
- Sub-word loads from word 0x8899AABB at 0x40:
  - byte 0x41, sign_ext=1 -> 0xFFFFFFAA
  - byte 0x41, sign_ext=0 -> 0x000000AA
  - half 0x42, sign_ext=1 -> 0xFFFF8899
  - byte 0x43, sign_ext=0 -> 0x00000088
- Store byte 0x5C to 0x42, then load word 0x40 -> 0x885CAABB; Mem_sel=10 during the store.
- Misaligned word load at 0x41:
  - With MISALIGN_TRAP_EN: done and misalign_err high cycle 1, no Mem_W_EN, rdata unchanged.
  - Without it: access proceeds at 0x40, misalign_err=0.
- WAIT_CYCLES=3 load with RST pulled low in cycle 2 -> no done pulse, ready=1 after reset. A repeat load of 0x40 gives done in cycle 5.
